// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: resolves MIPS branch/jump instructions in decode, computes the
// target and holds a registered redirect request until fetch accepts it.
// The word offset is formed internally as {imm[29:0], 2'b00}; a pending redirect
// back-pressures decode via id_ready.
// Optional build macro BRU_PERF_CNT_EN adds perf_taken / perf_nottaken counters.
module branch_redirect_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OP_W   = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [OP_W-1:0]   id_op,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] id_imm,
    input  logic [25:0]       id_index,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [ADDR_W-1:0] redir_target,
    output logic              redir_adel
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_taken,
    output logic [31:0]       perf_nottaken
`endif
);

    localparam logic [OP_W-1:0] OpBeq  = OP_W'(0);
    localparam logic [OP_W-1:0] OpBne  = OP_W'(1);
    localparam logic [OP_W-1:0] OpBgez = OP_W'(2);
    localparam logic [OP_W-1:0] OpBgtz = OP_W'(3);
    localparam logic [OP_W-1:0] OpBlez = OP_W'(4);
    localparam logic [OP_W-1:0] OpBltz = OP_W'(5);
    localparam logic [OP_W-1:0] OpJ    = OP_W'(6);
    localparam logic [OP_W-1:0] OpJr   = OP_W'(7);

    typedef enum logic [0:0] {StIdle, StPend} stateT;

    stateT             stateQ, stateD;
    logic [ADDR_W-1:0] targetQ;
    logic              adelQ;

    logic              accept;
    logic              taken;
    logic              rsNeg;
    logic              rsZero;
    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] branchOff;
    logic [ADDR_W-1:0] target;
    logic              adel;
    // The top two immediate bits fall off the word shift.
    logic              unusedImm;

    assign unusedImm = ^id_imm[ADDR_W-1:ADDR_W-2];

    assign id_ready     = (stateQ == StIdle);
    assign redir_valid  = (stateQ == StPend);
    assign redir_target = targetQ;
    assign redir_adel   = adelQ;

    assign accept    = id_valid & id_ready & ~flush;
    assign rsNeg     = id_rs[ADDR_W-1];
    assign rsZero    = (id_rs == '0);
    assign pcPlus4   = id_pc + ADDR_W'(4);
    assign branchOff = {id_imm[ADDR_W-3:0], 2'b00};

    // Resolve condition, target and address-error flag for the presented instruction.
    always_comb begin
        taken  = 1'b0;
        target = pcPlus4 + branchOff;
        adel   = 1'b0;
        case (id_op)
            OpBeq:  taken = (id_rs == id_rt);
            OpBne:  taken = (id_rs != id_rt);
            OpBgez: taken = ~rsNeg;
            OpBgtz: taken = ~rsNeg & ~rsZero;
            OpBlez: taken = rsNeg | rsZero;
            OpBltz: taken = rsNeg;
            OpJ: begin
                taken  = 1'b1;
                target = {pcPlus4[ADDR_W-1:ADDR_W-4], id_index, 2'b00};
            end
            OpJr: begin
                taken  = 1'b1;
                target = id_rs;
                adel   = |id_rs[1:0];
            end
            default: taken = 1'b0;
        endcase
    end

    // Next state: flush dominates, otherwise hold a taken redirect until fetch takes it.
    always_comb begin
        stateD = stateQ;
        if (flush) begin
            stateD = StIdle;
        end else begin
            unique case (stateQ)
                StIdle:  if (accept && taken) stateD = StPend;
                StPend:  if (redir_ready) stateD = StIdle;
                default: stateD = StIdle;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Capture target/adel on a taken accept; they stay stable while pending.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            targetQ <= '0;
            adelQ   <= 1'b0;
        end else if (accept && taken) begin
            targetQ <= target;
            adelQ   <= adel;
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perfTakenQ;
    logic [31:0] perfNotTakenQ;

    assign perf_taken    = perfTakenQ;
    assign perf_nottaken = perfNotTakenQ;

    // Count accepted instructions by outcome; flushed presentations are never accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perfTakenQ    <= '0;
            perfNotTakenQ <= '0;
        end else if (accept) begin
            if (taken) begin
                perfTakenQ <= perfTakenQ + 32'd1;
            end else begin
                perfNotTakenQ <= perfNotTakenQ + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed vectors, back-pressure, flush,
// asynchronous reset and randomized transactions against a behavioural model.
// Define BRU_PERF_CNT_EN to also exercise the performance counters.
module tb_branch_redirect_unit;

    logic        clock = 1'b0;
    logic        resetn;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_op;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [25:0] id_index;
    logic [31:0] id_rs;
    logic [31:0] id_rt;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_target;
    logic        redir_adel;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_taken;
    logic [31:0] perf_nottaken;
`endif

    int total = 0;
    int bad   = 0;

    branch_redirect_unit #(.ADDR_W(32), .OP_W(3)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_op        (id_op),
        .id_pc        (id_pc),
        .id_imm       (id_imm),
        .id_index     (id_index),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_target (redir_target),
        .redir_adel   (redir_adel)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_taken   (perf_taken),
        .perf_nottaken(perf_nottaken)
`endif
    );

    always #5 clock = ~clock;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Behavioural reference: architectural meaning of each opcode.
    function automatic void model(input logic [2:0] op, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [25:0] idx,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  output logic tk, output logic [31:0] tgt,
                                  output logic ad);
        int          srs;
        logic [31:0] p4;
        srs = rs;
        p4  = pc + 32'd4;
        tgt = p4 + (imm << 2);
        ad  = 1'b0;
        case (op)
            3'd0: tk = (rs == rt);
            3'd1: tk = (rs != rt);
            3'd2: tk = (srs >= 0);
            3'd3: tk = (srs > 0);
            3'd4: tk = (srs <= 0);
            3'd5: tk = (srs < 0);
            3'd6: begin tk = 1'b1; tgt = {p4[31:28], idx, 2'b00}; end
            default: begin tk = 1'b1; tgt = rs; ad = (rs % 4) != 0; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setIn(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt);
        id_op = op; id_pc = pc; id_imm = imm; id_index = idx; id_rs = rs; id_rt = rt;
    endtask

    task automatic applyReset();
        resetn = 1'b0; flush = 1'b0; id_valid = 1'b0; redir_ready = 1'b0;
        setIn(3'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        applyReset();
        total++;
        if (redir_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b expected 0", redir_valid);
        end
        total++;
        if (redir_target !== 32'h0) begin
            bad++; $display("FAIL reset_target: got %h expected 00000000", redir_target);
        end
        total++;
        if (redir_adel !== 1'b0) begin
            bad++; $display("FAIL reset_adel: got %b expected 0", redir_adel);
        end
        total++;
        if (id_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b expected 1", id_ready);
        end
`ifdef BRU_PERF_CNT_EN
        total++;
        if (perf_taken !== 32'h0 || perf_nottaken !== 32'h0) begin
            bad++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_taken, perf_nottaken);
        end
`endif
    endtask

    // Directed vectors with hand-computed targets, fetch always ready.
    task automatic test_directed();
        logic [2:0]  vOp  [5] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd0};
        logic [31:0] vPc  [5] = '{32'h0040_0100, 32'h0040_0200, 32'h0040_0200,
                                  32'h8FFF_FFFC, 32'hFFFF_FFF8};
        logic [31:0] vImm [5] = '{32'h4, 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h1};
        logic [25:0] vIdx [5] = '{26'h0, 26'h0, 26'h0, 26'h10, 26'h0};
        logic [31:0] vRs  [5] = '{32'd5, 32'd7, 32'hFFFF_FFFF, 32'h0, 32'd9};
        logic [31:0] vRt  [5] = '{32'd5, 32'd7, 32'h0, 32'h0, 32'd9};
        logic        vTk  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] vTgt [5] = '{32'h0040_0114, 32'h0, 32'h0040_0200,
                                  32'h9000_0040, 32'h0000_0000};
        for (int i = 0; i < 5; i++) begin
            setIn(vOp[i], vPc[i], vImm[i], vIdx[i], vRs[i], vRt[i]);
            id_valid = 1'b1; redir_ready = 1'b1;
            tick();
            id_valid = 1'b0;
            total++;
            if (redir_valid !== vTk[i]) begin
                bad++; $display("FAIL dir%0d_valid: got %b expected %b", i, redir_valid, vTk[i]);
            end
            if (vTk[i]) begin
                total++;
                if (redir_target !== vTgt[i] || redir_adel !== 1'b0) begin
                    bad++; $display("FAIL dir%0d_target: got %h/%b expected %h/0",
                                    i, redir_target, redir_adel, vTgt[i]);
                end
                tick();
            end
            total++;
            if (redir_valid !== 1'b0 || id_ready !== 1'b1) begin
                bad++; $display("FAIL dir%0d_done: got valid=%b ready=%b expected 0/1",
                                i, redir_valid, id_ready);
            end
        end
        redir_ready = 1'b0;
    endtask

    // JR with misaligned target held under back-pressure.
    task automatic test_backpressure();
        setIn(3'd7, 32'h0040_0000, 32'h0, 26'h0, 32'h1000_0002, 32'h0);
        id_valid = 1'b1; redir_ready = 1'b0;
        tick();
        id_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (redir_valid !== 1'b1 || redir_target !== 32'h1000_0002 ||
                redir_adel !== 1'b1 || id_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b t=%h a=%b r=%b expected 1/10000002/1/0",
                                c, redir_valid, redir_target, redir_adel, id_ready);
            end
            tick();
        end
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        total++;
        if (redir_valid !== 1'b0 || id_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: got v=%b r=%b expected 0/1", redir_valid, id_ready);
        end
    endtask

    task automatic test_flush();
        // Pending redirect dropped by flush, concurrent instruction ignored.
        setIn(3'd7, 32'h0, 32'h0, 26'h0, 32'h1000_0000, 32'h0);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        tick();
        setIn(3'd6, 32'h0040_0000, 32'h0, 26'h123, 32'h0, 32'h0);
        flush = 1'b1; redir_ready = 1'b1; id_valid = 1'b1;
        tick();
        flush = 1'b0; redir_ready = 1'b0; id_valid = 1'b0;
        total++;
        if (redir_valid !== 1'b0 || id_ready !== 1'b1) begin
            bad++; $display("FAIL flush_pend: got v=%b r=%b expected 0/1", redir_valid, id_ready);
        end
        tick();
        total++;
        if (redir_valid !== 1'b0) begin
            bad++; $display("FAIL flush_noaccept: got %b expected 0", redir_valid);
        end
        // Flush in idle blocks a taken jump.
        flush = 1'b1; id_valid = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        total++;
        if (redir_valid !== 1'b0) begin
            bad++; $display("FAIL flush_idle: got %b expected 0", redir_valid);
        end
        // Fetch ready with nothing pending changes nothing.
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        total++;
        if (redir_valid !== 1'b0 || id_ready !== 1'b1) begin
            bad++; $display("FAIL idle_ready: got v=%b r=%b expected 0/1", redir_valid, id_ready);
        end
    endtask

    task automatic test_async_reset();
        setIn(3'd6, 32'h0, 32'h0, 26'h3FF_FFFF, 32'h0, 32'h0);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        total++;
        if (redir_valid !== 1'b1) begin
            bad++; $display("FAIL areset_pre: got %b expected 1", redir_valid);
        end
        resetn = 1'b0;
        #1;
        total++;
        if (redir_valid !== 1'b0 || redir_target !== 32'h0 || id_ready !== 1'b1) begin
            bad++; $display("FAIL areset_drop: got v=%b t=%h r=%b expected 0/00000000/1",
                            redir_valid, redir_target, id_ready);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Random transactions: random fields, random stall length, id_valid asserted
    // while pending (must be ignored), and in the handshake cycle (must be ignored).
    task automatic test_random();
        logic [31:0] pool [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h0};
        logic [2:0]  op;
        logic [31:0] pc, imm, rs, rt, tgt;
        logic [25:0] idx;
        logic        tk, ad;
        for (int n = 0; n < 300; n++) begin
            op  = 3'($urandom_range(0, 7));
            pc  = $urandom;
            imm = ($urandom_range(0, 1) != 0) ? 32'($signed($urandom_range(0, 65535) - 32768))
                                              : $urandom;
            idx = 26'($urandom);
            pool[5] = $urandom;
            rs  = pool[$urandom_range(0, 5)];
            rt  = ($urandom_range(0, 2) == 0) ? rs : pool[$urandom_range(0, 5)];
            model(op, pc, imm, idx, rs, rt, tk, tgt, ad);
            setIn(op, pc, imm, idx, rs, rt);
            id_valid = 1'b1; redir_ready = 1'($urandom_range(0, 1));
            tick();
            id_valid = 1'b0; redir_ready = 1'b0;
            total++;
            if (redir_valid !== tk) begin
                bad++; $display("FAIL rnd%0d_valid op=%0d: got %b expected %b",
                                n, op, redir_valid, tk);
            end
            if (tk) begin
                total++;
                if (redir_target !== tgt || redir_adel !== ad || id_ready !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_out op=%0d: got t=%h a=%b r=%b expected %h/%b/0",
                                    n, op, redir_target, redir_adel, id_ready, tgt, ad);
                end
                for (int s = $urandom_range(0, 3); s > 0; s--) begin
                    setIn(3'd6, $urandom, $urandom, 26'($urandom), $urandom, $urandom);
                    id_valid = 1'($urandom_range(0, 1));
                    tick();
                    id_valid = 1'b0;
                    total++;
                    if (redir_valid !== 1'b1 || redir_target !== tgt || redir_adel !== ad) begin
                        bad++; $display("FAIL rnd%0d_hold: got v=%b t=%h a=%b expected 1/%h/%b",
                                        n, redir_valid, redir_target, redir_adel, tgt, ad);
                    end
                end
                setIn(3'd6, $urandom, $urandom, 26'($urandom), $urandom, $urandom);
                redir_ready = 1'b1; id_valid = 1'($urandom_range(0, 1));
                tick();
                redir_ready = 1'b0; id_valid = 1'b0;
                total++;
                if (redir_valid !== 1'b0 || id_ready !== 1'b1) begin
                    bad++; $display("FAIL rnd%0d_hs: got v=%b r=%b expected 0/1",
                                    n, redir_valid, id_ready);
                end
            end else begin
                total++;
                if (id_ready !== 1'b1) begin
                    bad++; $display("FAIL rnd%0d_ready: got %b expected 1", n, id_ready);
                end
            end
        end
    endtask

`ifdef BRU_PERF_CNT_EN
    task automatic test_perf();
        applyReset();
        for (int i = 0; i < 3; i++) begin
            setIn(3'd6, 32'h0040_0000, 32'h0, 26'(i), 32'h0, 32'h0);
            id_valid = 1'b1; redir_ready = 1'b1;
            tick();
            id_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            setIn(3'd1, 32'h0040_0000, 32'h4, 26'h0, 32'd3, 32'd3);
            id_valid = 1'b1;
            tick();
            id_valid = 1'b0;
        end
        setIn(3'd6, 32'h0040_0000, 32'h0, 26'h1, 32'h0, 32'h0);
        flush = 1'b1; id_valid = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0; redir_ready = 1'b0;
        tick();
        total++;
        if (perf_taken !== 32'd3) begin
            bad++; $display("FAIL perf_taken: got %0d expected 3", perf_taken);
        end
        total++;
        if (perf_nottaken !== 32'd2) begin
            bad++; $display("FAIL perf_nottaken: got %0d expected 2", perf_nottaken);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
`ifdef BRU_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
